sparse_array_sequencer: RTL and testbench

- Sequences compressed (index, value) operand streams into the top and left edges of an ARRAY_SIZE x ARRAY_SIZE sparse-PE systolic array.
- Holds one buffered stream per edge lane and applies the diagonal skew required by the one-cycle-per-hop PE forwarding.
- Terminates each stream with zero data, which the PEs treat as "finished".
- Waits for the array to drain, then pulses done; sits between the host/config interface and the array edges.

---
 rtl/sparse_pkg.sv | 23 ++
 rtl/sparse_lane_buffer.sv | 69 ++++++
 rtl/sparse_array_sequencer.sv | 138 +++++++++++++
 tb/tb_sparse_array_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pkg.sv
// Shared parameters, controller state encoding and the packed edge-element
// type for the sparse systolic-array sequencer.
package sparse_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int INDEX_SIZE = 3;
    localparam int ARRAY_SIZE = 8;
    localparam int MAX_NNZ    = 8;
    localparam int LANE_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [INDEX_SIZE-1:0] index;
        logic [DATA_WIDTH-1:0] data;
    } elem_t;

endpackage

// File: rtl/sparse_lane_buffer.sv
// One edge-lane stream store with a skewed, registered read: the lane emits
// element (t - LANE) while that position lies inside the stream window.
module sparse_lane_buffer
    import sparse_pkg::*;
#(
    parameter int DATA_WIDTH = sparse_pkg::DATA_WIDTH,
    parameter int INDEX_SIZE = sparse_pkg::INDEX_SIZE,
    parameter int MAX_NNZ    = sparse_pkg::MAX_NNZ,
    parameter int LANE_W     = sparse_pkg::LANE_W,
    parameter int TW         = LANE_W + 2,
    parameter int LANE       = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_we,
    input  logic [LANE_W-1:0]                i_addr,
    input  logic [INDEX_SIZE+DATA_WIDTH-1:0] i_wr_elem,
    input  logic                             i_rd_en,
    input  logic [TW-1:0]                    i_rd_t,
    output logic [INDEX_SIZE+DATA_WIDTH-1:0] o_elem
);

    localparam int EW = INDEX_SIZE + DATA_WIDTH;
    localparam logic [TW-1:0] LANE_T = TW'(LANE);
    localparam logic [TW-1:0] NNZ_T  = TW'(MAX_NNZ);

    logic [EW-1:0]     r_mem [MAX_NNZ];
    logic [TW-1:0]     w_rel;
    logic              w_hit;
    logic [LANE_W-1:0] w_ptr;
    logic [EW-1:0]     w_rd;

    assign w_rel = i_rd_t - LANE_T;
    assign w_hit = (i_rd_t >= LANE_T) && (w_rel < NNZ_T);
    assign w_ptr = w_rel[LANE_W-1:0];

    // Read port with write bypass so a write landing on the start edge is seen
    always_comb begin
        w_rd = r_mem[w_ptr];
        if (i_we && (i_addr == w_ptr)) begin
            w_rd = i_wr_elem;
        end else begin
            w_rd = r_mem[w_ptr];
        end
    end

    // Element store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_NNZ; i++) begin
                r_mem[i] <= {EW{1'b0}};
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wr_elem;
        end
    end

    // Registered edge output, zero outside the skew window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_elem <= {EW{1'b0}};
        end else if (i_rd_en && w_hit) begin
            o_elem <= w_rd;
        end else begin
            o_elem <= {EW{1'b0}};
        end
    end

endmodule

// File: rtl/sparse_array_sequencer.sv
// Feeds buffered (index, value) streams into the top and left edges of a
// sparse systolic array with diagonal skew, drains it, then pulses done.
module sparse_array_sequencer
    import sparse_pkg::*;
#(
    parameter int DATA_WIDTH = sparse_pkg::DATA_WIDTH,
    parameter int INDEX_SIZE = sparse_pkg::INDEX_SIZE,
    parameter int ARRAY_SIZE = sparse_pkg::ARRAY_SIZE,
    parameter int MAX_NNZ    = sparse_pkg::MAX_NNZ,
    parameter int LANE_W     = sparse_pkg::LANE_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_we,
    input  logic                             cfg_side,
    input  logic [LANE_W-1:0]                cfg_lane,
    input  logic [LANE_W-1:0]                cfg_addr,
    input  logic [DATA_WIDTH-1:0]            cfg_data,
    input  logic [INDEX_SIZE-1:0]            cfg_index,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] o_up,
    output logic [ARRAY_SIZE*INDEX_SIZE-1:0] o_up_index,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] o_left,
    output logic [ARRAY_SIZE*INDEX_SIZE-1:0] o_left_index
);

    localparam int TW = LANE_W + 2;
    localparam int EW = INDEX_SIZE + DATA_WIDTH;
    localparam logic [TW-1:0] F_LAST = TW'(MAX_NNZ + ARRAY_SIZE - 2);
    localparam logic [TW-1:0] D_LAST = TW'(2 * ARRAY_SIZE - 2);

    state_e        r_state, w_state_nxt;
    logic [TW-1:0] r_t, w_t_nxt, w_rd_t;
    logic          w_rd_en, w_wr_open, w_wr_go;
    logic          r_busy, r_done;
    logic          w_lane_ok, w_addr_ok;
    logic [EW-1:0] w_wr_elem;
    logic [EW-1:0] w_up_elem   [ARRAY_SIZE];
    logic [EW-1:0] w_left_elem [ARRAY_SIZE];

    // Next state, counter and read-slot selection
    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_rd_en     = 1'b0;
        w_rd_t      = r_t;
        w_wr_open   = 1'b0;
        case (r_state)
            IDLE: begin
                w_wr_open = 1'b1;
                if (start) begin
                    w_state_nxt = FEED;
                    w_t_nxt     = {TW{1'b0}};
                    w_rd_en     = 1'b1;
                    w_rd_t      = {TW{1'b0}};
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FEED: begin
                if (r_t == F_LAST) begin
                    w_state_nxt = DRAIN;
                    w_t_nxt     = {TW{1'b0}};
                end else begin
                    w_t_nxt = r_t + TW'(1);
                    w_rd_en = 1'b1;
                    w_rd_t  = r_t + TW'(1);
                end
            end
            DRAIN: begin
                if (r_t == D_LAST) begin
                    w_state_nxt = DONE;
                    w_t_nxt     = {TW{1'b0}};
                end else begin
                    w_t_nxt = r_t + TW'(1);
                end
            end
            DONE: begin
                w_wr_open   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_t_nxt     = {TW{1'b0}};
            end
        endcase
    end

    // State, counter and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_t     <= {TW{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            r_busy  <= (w_state_nxt == FEED) || (w_state_nxt == DRAIN);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign w_lane_ok = {1'b0, cfg_lane} < (LANE_W + 1)'(ARRAY_SIZE);
    assign w_addr_ok = {1'b0, cfg_addr} < (LANE_W + 1)'(MAX_NNZ);
    assign w_wr_go   = cfg_we && w_wr_open && w_lane_ok && w_addr_ok;
    assign w_wr_elem = {cfg_index, cfg_data};

    for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
        sparse_lane_buffer #(
            .DATA_WIDTH(DATA_WIDTH), .INDEX_SIZE(INDEX_SIZE), .MAX_NNZ(MAX_NNZ),
            .LANE_W(LANE_W), .TW(TW), .LANE(k)
        ) u_up (
            .clk(clk), .rst(rst),
            .i_we(w_wr_go && !cfg_side && (cfg_lane == LANE_W'(k))),
            .i_addr(cfg_addr), .i_wr_elem(w_wr_elem),
            .i_rd_en(w_rd_en), .i_rd_t(w_rd_t), .o_elem(w_up_elem[k])
        );
        sparse_lane_buffer #(
            .DATA_WIDTH(DATA_WIDTH), .INDEX_SIZE(INDEX_SIZE), .MAX_NNZ(MAX_NNZ),
            .LANE_W(LANE_W), .TW(TW), .LANE(k)
        ) u_left (
            .clk(clk), .rst(rst),
            .i_we(w_wr_go && cfg_side && (cfg_lane == LANE_W'(k))),
            .i_addr(cfg_addr), .i_wr_elem(w_wr_elem),
            .i_rd_en(w_rd_en), .i_rd_t(w_rd_t), .o_elem(w_left_elem[k])
        );
        assign o_up[k*DATA_WIDTH +: DATA_WIDTH]         = w_up_elem[k][DATA_WIDTH-1:0];
        assign o_up_index[k*INDEX_SIZE +: INDEX_SIZE]   = w_up_elem[k][EW-1:DATA_WIDTH];
        assign o_left[k*DATA_WIDTH +: DATA_WIDTH]       = w_left_elem[k][DATA_WIDTH-1:0];
        assign o_left_index[k*INDEX_SIZE +: INDEX_SIZE] = w_left_elem[k][EW-1:DATA_WIDTH];
    end

endmodule

// File: tb/tb_sparse_array_sequencer.sv
// Scoreboard bench: a stream-level model predicts every busy-cycle edge frame,
// a monitor compares them and checks run length and done pulses.
module tb_sparse_array_sequencer;
    import sparse_pkg::*;

    localparam int N  = ARRAY_SIZE;
    localparam int M  = MAX_NNZ;
    localparam int F  = M + N - 1;
    localparam int D  = 2 * N - 1;
    localparam int VW = N * DATA_WIDTH;
    localparam int IW = N * INDEX_SIZE;

    typedef struct packed {
        logic [VW-1:0] up;
        logic [IW-1:0] upi;
        logic [VW-1:0] lf;
        logic [IW-1:0] lfi;
    } frame_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cfg_we = 1'b0, cfg_side = 1'b0, start = 1'b0;
    logic [LANE_W-1:0]     cfg_lane = '0, cfg_addr = '0;
    logic [DATA_WIDTH-1:0] cfg_data = '0;
    logic [INDEX_SIZE-1:0] cfg_index = '0;
    logic                  busy, done;
    logic [VW-1:0]         o_up, o_left;
    logic [IW-1:0]         o_up_index, o_left_index;

    int     total = 0;
    int     bad = 0;
    int     bcnt = 0;
    int     ndone = 0;
    int     exp_done = 0;
    elem_t  m_up [N][M];
    elem_t  m_lf [N][M];
    frame_t q[$];

    sparse_array_sequencer dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_side(cfg_side),
        .cfg_lane(cfg_lane), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_index(cfg_index), .start(start), .busy(busy), .done(done),
        .o_up(o_up), .o_up_index(o_up_index), .o_left(o_left),
        .o_left_index(o_left_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic frame_t feed_frame(input int t);
        frame_t f = '0;
        for (int k = 0; k < N; k++) begin
            if (t - k >= 0 && t - k < M) begin
                f.up[k*DATA_WIDTH +: DATA_WIDTH]   = m_up[k][t-k].data;
                f.upi[k*INDEX_SIZE +: INDEX_SIZE]  = m_up[k][t-k].index;
                f.lf[k*DATA_WIDTH +: DATA_WIDTH]   = m_lf[k][t-k].data;
                f.lfi[k*INDEX_SIZE +: INDEX_SIZE]  = m_lf[k][t-k].index;
            end
        end
        return f;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < N; k++)
            for (int a = 0; a < M; a++) begin
                m_up[k][a] = '0;
                m_lf[k][a] = '0;
            end
    endtask

    task automatic set_cfg(input bit side, input int lane, input int addr,
                           input int idx, input int data, input bit apply);
        elem_t e;
        cfg_we    = 1'b1;
        cfg_side  = side;
        cfg_lane  = LANE_W'(lane);
        cfg_addr  = LANE_W'(addr);
        cfg_index = INDEX_SIZE'(idx);
        cfg_data  = DATA_WIDTH'(data);
        e.index   = INDEX_SIZE'(idx);
        e.data    = DATA_WIDTH'(data);
        if (apply) begin
            if (side) m_lf[lane][addr] = e;
            else      m_up[lane][addr] = e;
        end
    endtask

    task automatic wr(input bit side, input int lane, input int addr, input int idx, input int data);
        set_cfg(side, lane, addr, idx, data, 1'b1);
        tick();
        cfg_we = 1'b0;
    endtask

    // Expected frames come from the model as it stands when start is sampled
    task automatic run_start();
        for (int t = 0; t < F; t++) q.push_back(feed_frame(t));
        for (int t = 0; t < D; t++) q.push_back('0);
        exp_done++;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        chk("done_seen", {63'd0, done}, 64'd1);
        tick();
    endtask

    // Monitor: compare each busy cycle against the scoreboard, idle outputs must be zero
    always @(negedge clk) begin
        if (rst) begin
            bcnt = 0;
        end else if (busy) begin
            bcnt++;
            if (q.size() == 0) begin
                chk("unexpected_busy", 64'd1, 64'd0);
            end else begin
                frame_t e;
                e = q.pop_front();
                chk("o_up", 64'(o_up), 64'(e.up));
                chk("o_up_index", 64'(o_up_index), 64'(e.upi));
                chk("o_left", 64'(o_left), 64'(e.lf));
                chk("o_left_index", 64'(o_left_index), 64'(e.lfi));
            end
        end else begin
            chk("idle_outputs", 64'(o_up | o_left) | 64'(o_up_index | o_left_index), 64'd0);
            if (done) begin
                ndone++;
                chk("busy_len", 64'(bcnt), 64'(F + D));
                chk("queue_empty_at_done", 64'(q.size()), 64'd0);
                bcnt = 0;
            end
        end
    end

    initial begin
        clear_model();
        #2;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_up", 64'(o_up), 64'd0);
        chk("rst_left", 64'(o_left), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Short up-lane-0 stream terminated by zero
        wr(1'b0, 0, 0, 0, 3);
        wr(1'b0, 0, 1, 2, 5);
        wr(1'b0, 0, 2, 4, 0);
        run_start();
        wait_done();

        // Skewed single element on up lane 3
        wr(1'b0, 3, 0, 1, 7);
        run_start();
        wait_done();

        // Last window slot: left lane 7, position 7
        wr(1'b1, 7, 7, 7, 9);
        run_start();
        wait_done();

        // Write and start while busy are both ignored
        run_start();
        tick();
        tick();
        set_cfg(1'b0, 0, 0, 1, 8'h11, 1'b0);
        start = 1'b1;
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
        wait_done();
        run_start();
        wait_done();

        // Write lands on the same edge that samples start
        set_cfg(1'b1, 1, 0, 2, 8'h22, 1'b1);
        run_start();
        wait_done();

        // Randomized stream contents
        for (int r = 0; r < 6; r++) begin
            int nw = $urandom_range(1, 12);
            for (int w = 0; w < nw; w++) begin
                wr(1'($urandom_range(0, 1)), $urandom_range(0, N - 1), $urandom_range(0, M - 1),
                   $urandom_range(0, (1 << INDEX_SIZE) - 1),
                   ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255));
            end
            if ($urandom_range(0, 1) == 1) begin
                set_cfg(1'($urandom_range(0, 1)), $urandom_range(0, N - 1), 0,
                        $urandom_range(0, 7), $urandom_range(1, 255), 1'b1);
            end
            run_start();
            wait_done();
        end

        // Asynchronous reset in the middle of FEED at t=5
        run_start();
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_up", 64'(o_up) | 64'(o_up_index), 64'd0);
        chk("midrst_left", 64'(o_left) | 64'(o_left_index), 64'd0);
        q.delete();
        exp_done--;
        clear_model();
        tick();
        rst = 1'b0;
        tick();
        run_start();
        wait_done();

        repeat (3) tick();
        chk("done_count", 64'(ndone), 64'(exp_done));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
